// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One-hot owner encoding driven onto the grant port.
  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Grant state of the requester that does not currently own the FIFO.
  function automatic arb_state_t other_of(input arb_state_t s);
    return (s == GNT0) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter giving two valid/ready requesters bounded bursts into
// one shared write FIFO; ready and the write strobe follow fifo_full directly.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              fifo_w_en,
  output logic [DATA_W-1:0] fifo_w_data,
  output logic [1:0]        grant
);

  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_t       state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic              owner;
  logic              own_valid;
  logic              other_valid;
  logic [DATA_W-1:0] own_data;

  // Requester-relative view of the inputs while a grant is held.
  assign owner       = (state == GNT1);
  assign own_valid   = owner ? req1_valid : req0_valid;
  assign other_valid = owner ? req0_valid : req1_valid;
  assign own_data    = owner ? req1_data  : req0_data;

  assign grant      = grant_of(state);
  assign req0_ready = (state == GNT0) && !fifo_full;
  assign req1_ready = (state == GNT1) && !fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    fifo_w_en      = 1'b0;
    fifo_w_data    = '0;

    case (state)
      IDLE: begin
        // last_grant names the requester served most recently, so a tie goes to the other.
        if (req0_valid && req1_valid) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (req0_valid) begin
          state_nxt = GNT0;
        end else if (req1_valid) begin
          state_nxt = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (own_valid) begin
          // A full FIFO freezes the grant and the burst count; no switching on full.
          if (!fifo_full) begin
            fifo_w_en   = 1'b1;
            fifo_w_data = own_data;
            if (burst_cnt == CNT_LAST) begin
              burst_cnt_nxt = '0;
              if (other_valid) begin
                state_nxt      = other_of(state);
                last_grant_nxt = owner;
              end
            end else begin
              burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
          end
        end else begin
          burst_cnt_nxt  = '0;
          last_grant_nxt = owner;
          state_nxt      = other_valid ? other_of(state) : IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scenario bench for fifo_write_arbiter: requester queues feed the DUT and a
// scoreboard of expected FIFO writes is drained as fifo_w_en pulses appear.
module tb_fifo_write_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       fifo_full;
  logic       fifo_w_en;
  logic [7:0] fifo_w_data;
  logic [1:0] grant;

  int checks = 0;
  int passed = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];

  logic       s_w_en, s_r0, s_r1, s_full;
  logic [7:0] s_w_data;
  logic [1:0] s_grant;

  fifo_write_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_w_data(fifo_w_data),
    .grant      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters must hold valid and data until accepted.
  logic       p_v0 = 1'b0, p_a0 = 1'b0, p_v1 = 1'b0, p_a1 = 1'b0;
  logic [7:0] p_d0 = 8'h00, p_d1 = 8'h00;
  always @(posedge clk) begin
    if (!rst && p_v0 && !p_a0)
      assert (req0_valid && req0_data == p_d0) else $error("req0 dropped valid or data before acceptance");
    if (!rst && p_v1 && !p_a1)
      assert (req1_valid && req1_data == p_d1) else $error("req1 dropped valid or data before acceptance");
    p_v0 <= req0_valid && !rst;
    p_a0 <= req0_valid && req0_ready;
    p_d0 <= req0_data;
    p_v1 <= req1_valid && !rst;
    p_a1 <= req1_valid && req1_ready;
    p_d1 <= req1_data;
  end

  // One clock: present queue heads, sample outputs mid-cycle, retire accepted bytes.
  task automatic cyc();
    req0_valid = (q0.size() != 0);
    req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() != 0);
    req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    @(negedge clk);
    s_w_en   = fifo_w_en;
    s_w_data = fifo_w_data;
    s_grant  = grant;
    s_r0     = req0_ready;
    s_r1     = req1_ready;
    s_full   = fifo_full;
    @(posedge clk);
    if (req0_valid && s_r0) void'(q0.pop_front());
    if (req1_valid && s_r1) void'(q1.pop_front());
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    fifo_full  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_full = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b00) $display("FAIL reset grant: got %b want 00", grant); else passed++;
    checks++; if (req0_ready !== 1'b0) $display("FAIL reset req0_ready: got %b want 0", req0_ready); else passed++;
    checks++; if (req1_ready !== 1'b0) $display("FAIL reset req1_ready: got %b want 0", req1_ready); else passed++;
    checks++; if (fifo_w_en !== 1'b0) $display("FAIL reset fifo_w_en: got %b want 0", fifo_w_en); else passed++;
    checks++; if (fifo_w_data !== 8'h00) $display("FAIL reset fifo_w_data: got %h want 00", fifo_w_data); else passed++;
  endtask

  task automatic test_single();
    logic [1:0] eg [6];
    logic       ew [6];
    logic [4:0] ev;
    logic [7:0] ed;
    eg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    q0 = '{8'h11, 8'h22, 8'h33};
    exp_q = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 6; c++) begin
      cyc();
      ev = {eg[c], (eg[c] == 2'b01) && !s_full, (eg[c] == 2'b10) && !s_full, ew[c]};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL single ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL single write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL single data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL single idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL single drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_tie();
    logic [1:0] eg;
    logic       ew;
    logic [4:0] ev;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'h01 + 8'(i));
      q1.push_back(8'h81 + 8'(i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h01 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h81 + 8'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(8'h01 + 8'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(8'h81 + 8'(i));
    for (int c = 0; c < 19; c++) begin
      cyc();
      if (c == 0 || c == 18)    begin eg = 2'b00; ew = 1'b0; end
      else if (c == 17)         begin eg = 2'b10; ew = 1'b0; end
      else if (((c - 1) / 4) % 2 == 0) begin eg = 2'b01; ew = 1'b1; end
      else                      begin eg = 2'b10; ew = 1'b1; end
      ev = {eg, (eg == 2'b01) && !s_full, (eg == 2'b10) && !s_full, ew};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL tie ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL tie write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL tie data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL tie idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL tie drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_full_stall();
    logic [1:0] eg [15];
    logic       ew [15];
    logic [4:0] ev;
    logic [7:0] ed;
    eg = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
           2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    q1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hA5, 8'hA6};
    for (int c = 0; c < 15; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      if (c == 2) q0 = '{8'hB1, 8'hB2};
      cyc();
      ev = {eg[c], (eg[c] == 2'b01) && !s_full, (eg[c] == 2'b10) && !s_full, ew[c]};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL stall ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL stall write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL stall data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL stall idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    fifo_full = 1'b0;
    checks++; if (exp_q.size() != 0) $display("FAIL stall drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_early_release();
    logic [1:0] eg [8];
    logic       ew [8];
    logic [4:0] ev;
    logic [7:0] ed;
    eg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    q0 = '{8'hC1, 8'hC2};
    q1 = '{8'hD1, 8'hD2};
    exp_q = '{8'hC1, 8'hC2, 8'hD1, 8'hD2};
    for (int c = 0; c < 8; c++) begin
      cyc();
      ev = {eg[c], (eg[c] == 2'b01) && !s_full, (eg[c] == 2'b10) && !s_full, ew[c]};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL release ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL release write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL release data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL release idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
      if (c == 4) begin
        checks++;
        if (dut.last_grant !== 1'b0) $display("FAIL release last_grant: got %b want 0", dut.last_grant); else passed++;
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL release drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] eg [6];
    logic       ew [6];
    logic [1:0] pg [8];
    logic       pw [8];
    logic [4:0] ev;
    logic [7:0] ed;
    eg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    pw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    // A first lone req0 burst leaves last_grant=0, so reset must restore the req0 tie win.
    q0 = '{8'hE1};
    exp_q = '{8'hE1, 8'hE2, 8'hE3};
    for (int c = 0; c < 6; c++) begin
      if (c == 3) q0 = '{8'hE2, 8'hE3, 8'hE4, 8'hE5};
      cyc();
      ev = {eg[c], (eg[c] == 2'b01) && !s_full, (eg[c] == 2'b10) && !s_full, ew[c]};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL midrst ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL midrst write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL midrst data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL midrst idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    req0_valid = 1'b1;
    req0_data  = q0[0];
    #2;
    checks++;
    if ({fifo_w_en, fifo_w_data} !== {1'b1, 8'hE4})
      $display("FAIL midrst pre-reset write: got %b/%h want 1/e4", fifo_w_en, fifo_w_data);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({grant, req0_ready, req1_ready, fifo_w_en, fifo_w_data} !== 13'd0)
      $display("FAIL midrst async outputs: got %b/%b/%b/%b/%h want all zero",
               grant, req0_ready, req1_ready, fifo_w_en, fifo_w_data);
    else passed++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    q1 = '{8'hF1, 8'hF2};
    exp_q = '{8'hE4, 8'hE5, 8'hF1, 8'hF2};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      ev = {pg[c], (pg[c] == 2'b01) && !s_full, (pg[c] == 2'b10) && !s_full, pw[c]};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL midrst post ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL midrst post write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL midrst post data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL midrst post idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL midrst drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_lone_burst();
    logic [1:0] eg;
    logic       ew;
    logic [4:0] ev;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q1.push_back(8'h91 + 8'(i));
      exp_q.push_back(8'h91 + 8'(i));
    end
    for (int c = 0; c < 9; c++) begin
      cyc();
      eg = (c == 0 || c == 8) ? 2'b00 : 2'b10;
      ew = (c >= 1 && c <= 6);
      ev = {eg, (eg == 2'b01) && !s_full, (eg == 2'b10) && !s_full, ew};
      checks++;
      if ({s_grant, s_r0, s_r1, s_w_en} !== ev)
        $display("FAIL lone ctl c%0d: got %b want %b", c, {s_grant, s_r0, s_r1, s_w_en}, ev);
      else passed++;
      checks++;
      if (s_w_en) begin
        if (exp_q.size() == 0) $display("FAIL lone write c%0d: got %h with none expected", c, s_w_data);
        else begin
          ed = exp_q.pop_front();
          if (s_w_data !== ed) $display("FAIL lone data c%0d: got %h want %h", c, s_w_data, ed); else passed++;
        end
      end else if (s_w_data !== 8'h00) $display("FAIL lone idle data c%0d: got %h want 00", c, s_w_data);
      else passed++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL lone drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
    test_reset();
    test_single();
    test_tie();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_lone_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
